// File: rtl/divider.sv
// Iterative radix-2^B integer divider for DIV/DIVU/REM/REMU and their W forms.
// Sits beside the multiplier in EX and holds the stage via stall_o while it iterates.

package rei_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic is_div;
    logic is_rem;
    logic is_signed;
    logic is_word;
  } div_ctrl_s;
endpackage

module divider #(
  parameter int XLEN               = rei_pkg::XLEN,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                stall_o,
  input  rei_pkg::div_ctrl_s  div_ctrl_i,
  input  logic [XLEN-1:0]     src1_i,
  input  logic [XLEN-1:0]     src2_i,
  output logic [XLEN-1:0]     rslt_o
);

  localparam int N  = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  if (!(XLEN == 32 || XLEN == 64) ||
      !(DIV_BITS_PER_CYCLE == 1 || DIV_BITS_PER_CYCLE == 2 || DIV_BITS_PER_CYCLE == 4) ||
      (XLEN % DIV_BITS_PER_CYCLE) != 0) begin : g_bad_param
    $fatal(1, "divider: illegal XLEN / DIV_BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e state, state_next;

  logic            start;
  logic            word_op;
  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_val, special_res;
  logic            sign_a, sign_b, div_zero, overflow;

  logic [XLEN-1:0] quo, prem, dvs, result;
  logic            neg_quo, neg_rem, rem_sel, word_sel;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] quo_next, rem_next, quo_fin, rem_fin, final_res;

  // Word results keep only the low half, sign-extended from bit 31.
  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  assign start   = valid_i && div_ctrl_i.is_div;
  assign word_op = (XLEN == 64) && div_ctrl_i.is_word;

  // Bring operands to the operating width, take magnitudes and spot the special cases.
  always_comb begin
    ext_a = src1_i;
    ext_b = src2_i;
    if (word_op) begin
      if (div_ctrl_i.is_signed) begin
        ext_a = XLEN'($signed(src1_i[31:0]));
        ext_b = XLEN'($signed(src2_i[31:0]));
      end else begin
        ext_a = XLEN'(src1_i[31:0]);
        ext_b = XLEN'(src2_i[31:0]);
      end
    end
    sign_a  = div_ctrl_i.is_signed && ext_a[XLEN-1];
    sign_b  = div_ctrl_i.is_signed && ext_b[XLEN-1];
    mag_a   = sign_a ? -ext_a : ext_a;
    mag_b   = sign_b ? -ext_b : ext_b;
    min_val = word_op ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (ext_b == '0);
    overflow = div_ctrl_i.is_signed && (ext_a == min_val) && (ext_b == '1);
    if (div_zero)
      special_res = div_ctrl_i.is_rem ? fit(ext_a, word_op) : '1;
    else
      special_res = div_ctrl_i.is_rem ? '0 : fit(ext_a, word_op);
  end

  // One iteration of restoring division, retiring DIV_BITS_PER_CYCLE quotient bits.
  always_comb begin
    logic [XLEN:0] trial;
    quo_next = quo;
    rem_next = prem;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      trial    = {rem_next, quo_next[XLEN-1]};
      quo_next = {quo_next[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dvs}) begin
        trial       = trial - {1'b0, dvs};
        quo_next[0] = 1'b1;
      end
      rem_next = trial[XLEN-1:0];
    end
    quo_fin   = neg_quo ? -quo_next : quo_next;
    rem_fin   = neg_rem ? -rem_next : rem_next;
    final_res = fit(rem_sel ? rem_fin : quo_fin, word_sel);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: accept in IDLE, iterate or abort on flush in BUSY, present once in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (div_zero || overflow) ? DONE : BUSY;
      BUSY: begin
        if (!valid_i)         state_next = IDLE;
        else if (count == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: stall while accepting or iterating, result only while in DONE.
  always_comb begin
    stall_o = 1'b0;
    rslt_o  = '0;
    case (state)
      IDLE:    stall_o = start;
      BUSY:    stall_o = 1'b1;
      DONE:    rslt_o  = result;
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, iterate in BUSY, latch the signed-corrected result on the last step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo      <= '0;
      prem     <= '0;
      dvs      <= '0;
      result   <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      rem_sel  <= 1'b0;
      word_sel <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            quo      <= mag_a;
            prem     <= '0;
            dvs      <= mag_b;
            neg_quo  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            rem_sel  <= div_ctrl_i.is_rem;
            word_sel <= word_op;
            count    <= CW'(N - 1);
            if (div_zero || overflow) result <= special_res;
          end
        end
        BUSY: begin
          quo   <= quo_next;
          prem  <= rem_next;
          count <= count - 1'b1;
          if (count == '0) result <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative radix-2^B integer divider for the RV M-extension DIV/DIVU/REM/REMU and their W forms.
- Sits in the execute stage next to the multiplier. It uses the same stall-and-hold protocol: the instruction stays in EX while stall_o is high.
- Its rslt_o is ORed into the execute result bus alongside the multiplier result. The output is zero whenever the result is not being presented.
- div_ctrl_s is a new struct in rei_pkg with fields: is_div, is_rem, is_signed, is_word.

Parameters:
- XLEN, from rei_pkg (32 or 64): operand and result width.
- DIV_BITS_PER_CYCLE, default 1: quotient bits retired per iteration. Legal values are 1, 2, 4. Any other value, or XLEN not divisible by it, triggers `FATAL at elaboration.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  EX-stage instruction valid
- stall_o  out  1  hold the EX stage
- div_ctrl_i  in  div_ctrl_s  decoded divide control
- src1_i  in  XLEN  dividend (rs1)
- src2_i  in  XLEN  divisor (rs2)
- rslt_o  out  XLEN  result; zero unless in DONE

Behaviour:
- Reset (rst_i=1 on a clock edge): state=IDLE, counter=0, operand/partial registers cleared. Applies mid-operation as well. While in IDLE with no request: stall_o=0, rslt_o=0.
- Let N = XLEN/DIV_BITS_PER_CYCLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start = valid_i && div_ctrl_i.is_div:
  - stall_o = start (combinational).
  - On start, capture operands, ctrl and sign flags.
  - Special case (divisor==0, or signed overflow) -> DONE.
  - Otherwise -> BUSY with counter=N-1.
- BUSY:
  - stall_o=1.
  - Each cycle shifts and subtracts DIV_BITS_PER_CYCLE bits (restoring division on magnitudes); counter decrements.
  - At counter==0 -> DONE.
  - If valid_i==0 in BUSY (pipeline flush), abort -> IDLE. No result is presented.
- DONE:
  - stall_o=0, rslt_o=final result, unconditionally -> IDLE.
  - The held instruction leaves EX this cycle. The same instruction must not restart: start is ignored in DONE.
- Latency, normal path: stall_o high for N+1 consecutive cycles (1 IDLE + N BUSY); result appears in the following cycle (DONE).
- Latency, special cases: stall_o high for 1 cycle, then DONE.
- Signed ops: divide magnitudes. Quotient sign = sign1 XOR sign2. Remainder sign = dividend sign. Negation is applied in the final BUSY cycle, so DONE reads a register.
- Word ops (XLEN=64 only; is_word is ignored when XLEN=32):
  - Operands are the low 32 bits, sign- or zero-extended per is_signed.
  - Result is the low 32 bits sign-extended from bit 31.
  - Iteration count is still N (no early-out).
- Divide by zero:
  - quotient = all ones (-1).
  - remainder = dividend. For word ops, use the truncated 32-bit dividend, sign-extended.
- Signed overflow (dividend = most-negative, divisor = -1, at the operating width):
  - quotient = dividend.
  - remainder = 0.
- is_rem selects remainder, else quotient.
- rslt_o is registered-state based: it depends only on state and internal registers, with no combinational path from src*_i.
- stall_o is combinational from valid_i/div_ctrl_i only in IDLE.
- valid_i with is_div=0: no effect, stall_o=0, rslt_o=0.

Test Plan:
- XLEN=32, B=1: DIVU 100/7.
  - stall_o high exactly 33 cycles.
  - Next cycle: rslt_o=14, stall_o=0.
  - Following cycle: rslt_o=0, state IDLE.
- Signed sign rules: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 0x80000000/0 -> 0x80000000.
  - stall_o high 1 cycle only.
- Signed overflow:
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000, 1-cycle stall.
  - REM of the same -> 0.
  - DIVU of the same operands takes the full 33-cycle path -> 0.
- XLEN=64, word op: DIVW src1=0x00000000_FFFFFFF0, src2=4 -> 0xFFFFFFFF_FFFFFFFC (-16/4 = -4, sign-extended).
- Abort paths:
  - Drop valid_i at BUSY cycle 10 -> IDLE next cycle, stall_o=0, rslt_o stays 0.
  - Assert rst_i at BUSY cycle 5 -> same outcome.
  - Then a new DIVU 9/3 -> 3 with normal latency.
- Throughput: with B=4, two back-to-back DIVs each stall 9 cycles. The second DIV is accepted the cycle after the first one's DONE.
